// File: rtl/fft4_stream.sv
// fft4_stream: streaming radix-4 DFT over 4-sample frames.
//
// Purpose:
//   Collects four complex samples over a valid/ready input handshake,
//   computes the 4-point DFT (forward or inverse, optionally scaled by 1/4)
//   in two registered butterfly stages, then returns the four bins serially
//   in natural order over a valid/ready output handshake.
//
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   in_valid / in_ready   input sample handshake
//   in_real, in_imag      signed input sample, DATA_WIDTH bits each
//   in_inv                frame mode, taken with sample 0 (1 = inverse)
//   out_valid / out_ready output bin handshake
//   out_real, out_imag    signed output bin, DATA_WIDTH+2 bits each
//   out_index             bin number of the presented output
//   out_last              marks bin 3, the final bin of a frame
module fft4_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int SCALE      = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_real,
    input  logic signed [DATA_WIDTH-1:0] in_imag,
    input  logic                         in_inv,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH+1:0] out_real,
    output logic signed [DATA_WIDTH+1:0] out_imag,
    output logic [1:0]                   out_index,
    output logic                         out_last
);

    localparam int OW = DATA_WIDTH + 2;

    typedef enum logic [1:0] {LOAD, STG1, STG2, UNLOAD} state_t;

    state_t state_q, state_d;
    logic [1:0] n_q, n_d;
    logic [1:0] k_q, k_d;
    logic       inv_q, inv_d;

    logic signed [DATA_WIDTH-1:0] xr_q [4];
    logic signed [DATA_WIDTH-1:0] xr_d [4];
    logic signed [DATA_WIDTH-1:0] xi_q [4];
    logic signed [DATA_WIDTH-1:0] xi_d [4];
    logic signed [OW-1:0]         ar_q [4];
    logic signed [OW-1:0]         ar_d [4];
    logic signed [OW-1:0]         ai_q [4];
    logic signed [OW-1:0]         ai_d [4];
    logic signed [OW-1:0]         br_q [4];
    logic signed [OW-1:0]         br_d [4];
    logic signed [OW-1:0]         bi_q [4];
    logic signed [OW-1:0]         bi_d [4];

    logic signed [OW-1:0] f1r, f1i, f3r, f3i;
    logic                 in_hs;

    function automatic logic signed [OW-1:0] sext(input logic signed [DATA_WIDTH-1:0] v);
        return {{2{v[DATA_WIDTH-1]}}, v};
    endfunction

    // Optional 1/4 scaling applied to the full-growth result (floor).
    function automatic logic signed [OW-1:0] scl(input logic signed [OW-1:0] v);
        if (SCALE != 0) begin
            return v >>> 2;
        end
        return v;
    endfunction

    // in_ready is forced low during reset so nothing is accepted that cycle.
    assign in_ready = (state_q == LOAD) && !rst;
    assign in_hs    = in_valid && in_ready;

    // Odd-bin cross terms: multiply the x1-x3 difference by -j or +j.
    assign f1r = ar_q[1] + ai_q[3];
    assign f1i = ai_q[1] - ar_q[3];
    assign f3r = ar_q[1] - ai_q[3];
    assign f3i = ai_q[1] + ar_q[3];

    // Outputs are zeroed outside UNLOAD so nothing stale is ever visible.
    assign out_valid = (state_q == UNLOAD);
    assign out_real  = out_valid ? br_q[k_q] : '0;
    assign out_imag  = out_valid ? bi_q[k_q] : '0;
    assign out_index = k_q;
    assign out_last  = out_valid && (k_q == 2'd3);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        k_d     = k_q;
        inv_d   = inv_q;
        xr_d    = xr_q;
        xi_d    = xi_q;
        ar_d    = ar_q;
        ai_d    = ai_q;
        br_d    = br_q;
        bi_d    = bi_q;

        case (state_q)
            LOAD: begin
                if (in_hs) begin
                    xr_d[n_q] = in_real;
                    xi_d[n_q] = in_imag;
                    if (n_q == 2'd0) begin
                        inv_d = in_inv;
                    end
                    if (n_q == 2'd3) begin
                        state_d = STG1;
                        n_d     = 2'd0;
                    end else begin
                        n_d = n_q + 2'd1;
                    end
                end
            end
            STG1: begin
                ar_d[0] = sext(xr_q[0]) + sext(xr_q[2]);
                ai_d[0] = sext(xi_q[0]) + sext(xi_q[2]);
                ar_d[1] = sext(xr_q[0]) - sext(xr_q[2]);
                ai_d[1] = sext(xi_q[0]) - sext(xi_q[2]);
                ar_d[2] = sext(xr_q[1]) + sext(xr_q[3]);
                ai_d[2] = sext(xi_q[1]) + sext(xi_q[3]);
                ar_d[3] = sext(xr_q[1]) - sext(xr_q[3]);
                ai_d[3] = sext(xi_q[1]) - sext(xi_q[3]);
                state_d = STG2;
            end
            STG2: begin
                br_d[0] = scl(ar_q[0] + ar_q[2]);
                bi_d[0] = scl(ai_q[0] + ai_q[2]);
                br_d[2] = scl(ar_q[0] - ar_q[2]);
                bi_d[2] = scl(ai_q[0] - ai_q[2]);
                // Inverse mode swaps the roles of the two odd bins.
                if (inv_q) begin
                    br_d[1] = scl(f3r);
                    bi_d[1] = scl(f3i);
                    br_d[3] = scl(f1r);
                    bi_d[3] = scl(f1i);
                end else begin
                    br_d[1] = scl(f1r);
                    bi_d[1] = scl(f1i);
                    br_d[3] = scl(f3r);
                    bi_d[3] = scl(f3i);
                end
                state_d = UNLOAD;
            end
            UNLOAD: begin
                if (out_ready) begin
                    if (k_q == 2'd3) begin
                        state_d = LOAD;
                        k_d     = 2'd0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            n_q     <= 2'd0;
            k_q     <= 2'd0;
            inv_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                xr_q[i] <= '0;
                xi_q[i] <= '0;
                ar_q[i] <= '0;
                ai_q[i] <= '0;
                br_q[i] <= '0;
                bi_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            k_q     <= k_d;
            inv_q   <= inv_d;
            xr_q    <= xr_d;
            xi_q    <= xi_d;
            ar_q    <= ar_d;
            ai_q    <= ai_d;
            br_q    <= br_d;
            bi_q    <= bi_d;
        end
    end

endmodule

// File: tb/tb_fft4_stream.sv
// tb_fft4_stream: scoreboard bench for fft4_stream.
//
// Two instances share all inputs: one with full growth, one with 1/4
// scaling. The stimulus side pushes reference DFT bins for each completed
// frame; a monitor pops and compares them on every output handshake,
// checks held outputs under backpressure, and tracks in_ready.
module tb_fft4_stream;

    localparam int DW = 8;
    localparam int OW = DW + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic signed [DW-1:0] in_real = '0;
    logic signed [DW-1:0] in_imag = '0;
    logic in_inv = 1'b0;
    logic out_ready = 1'b1;

    logic in_ready0, out_valid0, out_last0;
    logic signed [OW-1:0] out_real0, out_imag0;
    logic [1:0] out_index0;
    logic in_ready1, out_valid1, out_last1;
    logic signed [OW-1:0] out_real1, out_imag1;
    logic [1:0] out_index1;

    always #5 clk = ~clk;

    fft4_stream #(.DATA_WIDTH(DW), .SCALE(0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_real(in_real), .in_imag(in_imag), .in_inv(in_inv),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_real(out_real0), .out_imag(out_imag0),
        .out_index(out_index0), .out_last(out_last0)
    );

    fft4_stream #(.DATA_WIDTH(DW), .SCALE(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready1),
        .in_real(in_real), .in_imag(in_imag), .in_inv(in_inv),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_real(out_real1), .out_imag(out_imag1),
        .out_index(out_index1), .out_last(out_last1)
    );

    typedef struct {
        int r0;
        int i0;
        int r1;
        int i1;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   busy = 1'b0;
    bit   rand_ready = 1'b0;
    int   sent = 0;
    bit   frame_inv = 1'b0;
    int   fr[4];
    int   fi[4];
    int   vr[4];
    int   vi[4];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Multiply (re,im) by (-j)^m.
    function automatic void rot(input int re, input int im, input int m,
                                output int orr, output int oi);
        case (m & 3)
            0: begin orr = re;  oi = im;  end
            1: begin orr = im;  oi = -re; end
            2: begin orr = -re; oi = -im; end
            default: begin orr = -im; oi = re; end
        endcase
    endfunction

    // Direct DFT sum over the captured frame; inverse uses the conjugate twiddle.
    task automatic pushFrame();
        exp_t e;
        int sr, si, tr, ti, m;
        for (int k = 0; k < 4; k++) begin
            sr = 0;
            si = 0;
            for (int n = 0; n < 4; n++) begin
                m = (n * k) % 4;
                if (frame_inv) m = (4 - m) % 4;
                rot(fr[n], fi[n], m, tr, ti);
                sr += tr;
                si += ti;
            end
            e.r0  = sr;
            e.i0  = si;
            e.r1  = sr >>> 2;
            e.i1  = si >>> 2;
            e.idx = k;
            sb.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int re, input int im, input bit inv, input int bubbles);
        int guard;
        in_valid = 1'b0;
        repeat (bubbles) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_real  = re[DW-1:0];
        in_imag  = im[DW-1:0];
        in_inv   = inv;
        guard    = 0;
        @(negedge clk);
        while (!in_ready0 && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready0) begin
            bad++;
            $display("[TB] FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
            $display("test done: total=%0d bad=%0d", total, bad);
            $fatal(1, "[TB] input handshake timed out");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        fr[sent] = re;
        fi[sent] = im;
        if (sent == 0) frame_inv = inv;
        sent++;
        if (sent == 4) begin
            pushFrame();
            busy = 1'b1;
            sent = 0;
        end
    endtask

    task automatic sendFrame(input bit inv0, input bit inv_rest, input int max_bubble);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(vr[n], vi[n], (n == 0) ? inv0 : inv_rest,
                          (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0);
        end
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        sent = 0;
        busy = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", int'(out_valid0), 0);
        checkOutput("rst_out_real", int'(out_real0), 0);
        checkOutput("rst_out_imag", int'(out_imag0), 0);
        checkOutput("rst_out_index", int'(out_index0), 0);
        checkOutput("rst_out_last", int'(out_last0), 0);
        checkOutput("rst_in_ready", int'(in_ready0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: everything is sampled on the falling edge, between active edges.
    bit   held = 1'b0;
    int   h_r0, h_i0, h_r1, h_i1, h_idx, h_last;

    always @(negedge clk) begin
        checkOutput("in_ready", int'(in_ready0), int'(!busy && !rst));
        checkOutput("in_ready_scaled", int'(in_ready1), int'(in_ready0));
        if (held) begin
            checkOutput("hold_valid", int'(out_valid0), 1);
            checkOutput("hold_real", int'(out_real0), h_r0);
            checkOutput("hold_imag", int'(out_imag0), h_i0);
            checkOutput("hold_real_s", int'(out_real1), h_r1);
            checkOutput("hold_imag_s", int'(out_imag1), h_i1);
            checkOutput("hold_index", int'(out_index0), h_idx);
            checkOutput("hold_last", int'(out_last0), h_last);
        end
        held = 1'b0;
        if (out_valid0 === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_bin", 1, 0);
            end else if (out_ready) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("bin_real", int'(out_real0), e.r0);
                checkOutput("bin_imag", int'(out_imag0), e.i0);
                checkOutput("bin_real_scaled", int'(out_real1), e.r1);
                checkOutput("bin_imag_scaled", int'(out_imag1), e.i1);
                checkOutput("bin_index", int'(out_index0), e.idx);
                checkOutput("bin_last", int'(out_last0), int'(e.idx == 3));
                checkOutput("valid_scaled", int'(out_valid1), 1);
                if (e.idx == 3) busy = 1'b0;
            end else begin
                held   = 1'b1;
                h_r0   = int'(out_real0);
                h_i0   = int'(out_imag0);
                h_r1   = int'(out_real1);
                h_i1   = int'(out_imag1);
                h_idx  = int'(out_index0);
                h_last = int'(out_last0);
            end
        end
    end

    initial begin
        int guard;
        $display("[TB] starting fft4_stream bench");
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("init_out_valid", int'(out_valid0), 0);
        checkOutput("init_out_index", int'(out_index0), 0);
        checkOutput("init_out_last", int'(out_last0), 0);
        checkOutput("init_out_real", int'(out_real0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Forward frame with first-output latency check.
        vr = '{1, 2, -1, 3};
        vi = '{0, 0, 0, 0};
        sendFrame(1'b0, 1'b0, 0);
        @(negedge clk);
        checkOutput("latency_stg1", int'(out_valid0), 0);
        @(negedge clk);
        checkOutput("latency_stg2", int'(out_valid0), 0);
        @(negedge clk);
        checkOutput("latency_unload", int'(out_valid0), 1);

        // Inverse frame, then forward again with in_inv high on samples 1-3.
        sendFrame(1'b1, 1'b0, 0);
        sendFrame(1'b0, 1'b1, 0);

        // Full-scale negative frame.
        vr = '{-128, -128, -128, -128};
        vi = '{-128, -128, -128, -128};
        sendFrame(1'b0, 1'b0, 1);

        // Abort a frame after three samples, then a clean impulse frame.
        vr = '{7, -9, 11, 0};
        vi = '{3, 5, -6, 0};
        for (int n = 0; n < 3; n++) applyStimulus(vr[n], vi[n], 1'b1, 0);
        pulseReset();
        vr = '{4, 0, 0, 0};
        vi = '{0, 0, 0, 0};
        sendFrame(1'b0, 1'b0, 0);

        // Random frames with input bubbles and output backpressure.
        rand_ready = 1'b1;
        for (int f = 0; f < 30; f++) begin
            for (int n = 0; n < 4; n++) begin
                vr[n] = int'($urandom_range(0, 255)) - 128;
                vi[n] = int'($urandom_range(0, 255)) - 128;
            end
            sendFrame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
            guard++;
            @(posedge clk);
        end
        rand_ready = 1'b0;
        repeat (20) @(posedge clk);
        checkOutput("drain_empty", sb.size(), 0);
        @(negedge clk);
        checkOutput("idle_out_valid", int'(out_valid0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
